// File: rtl/video_ip_pkg.sv
// Shared definitions for the video IP frame reader: default widths, FSM states, bus step.
package video_ip_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_LEN_W      = 24;
    localparam int unsigned DEF_MAX_PEND   = 4;
    localparam int unsigned DEF_FIFO_DEPTH = 8;

    // Byte distance between consecutive words on the Avalon byte-addressed bus.
    function automatic int unsigned addr_step(input int unsigned data_w);
        return data_w / 8;
    endfunction

    localparam int unsigned AVM_WORD_BYTES = addr_step(DEF_DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head taken straight from storage registers.
module sync_fifo #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [DATA_W-1:0]      push_data,
    input  logic                   pop,
    output logic [DATA_W-1:0]      head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    // Storage write; data contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/avalon_mm_master_frame_reader.sv
// Avalon-MM read master: fetches num_words words from base_addr with pipelined reads
// and streams them out through a credit-protected FIFO.
module avalon_mm_master_frame_reader
    import video_ip_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LEN_W      = DEF_LEN_W,
    parameter int unsigned MAX_PEND   = DEF_MAX_PEND,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned PEND_W = $clog2(MAX_PEND + 1);
    localparam int unsigned SUM_W  = ((CNT_W > PEND_W) ? CNT_W : PEND_W) + 1;
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(addr_step(DATA_W));

    rd_state_t         state;
    logic [LEN_W-1:0]  remaining;
    logic [LEN_W-1:0]  remaining_nxt;
    logic [PEND_W-1:0] pending;
    logic [PEND_W-1:0] pending_nxt;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_nxt;
    logic [SUM_W-1:0]  occupancy_nxt;
    logic              fifo_empty;
    logic              fifo_full;
    logic              accept;
    logic              push;
    logic              pop;
    logic              credit_ok;

    // Bus handshakes; responses with nothing outstanding are stale and dropped.
    assign accept    = avm_read && !avm_waitrequest;
    assign pop       = out_valid && out_ready;
    assign push      = avm_readdatavalid && (pending != '0) && (!fifo_full || pop);
    assign out_valid = !fifo_empty;

    // Post-edge view of the counters so the registered read request never overcommits the FIFO.
    assign pending_nxt   = pending + PEND_W'(accept) - PEND_W'(push);
    assign count_nxt     = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign remaining_nxt = accept ? (remaining - LEN_W'(1)) : remaining;
    assign occupancy_nxt = SUM_W'(pending_nxt) + SUM_W'(count_nxt);
    assign credit_ok     = (remaining_nxt != '0)
                        && (occupancy_nxt < SUM_W'(FIFO_DEPTH))
                        && (pending_nxt < PEND_W'(MAX_PEND));

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (avm_readdata),
        .pop       (pop),
        .head      (out_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Transfer FSM with address/remaining/pending counters and registered bus outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            avm_read    <= 1'b0;
            avm_address <= '0;
            remaining   <= '0;
            pending     <= '0;
        end else begin
            done    <= 1'b0;
            pending <= pending_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        avm_address <= base_addr;
                        remaining   <= num_words;
                        busy        <= 1'b1;
                        if (num_words == '0) begin
                            state <= ST_FINISH;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_ISSUE;
                            avm_read <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (accept) begin
                        avm_address <= avm_address + ADDR_STEP;
                        remaining   <= remaining_nxt;
                        if (remaining == LEN_W'(1)) begin
                            state    <= ST_DRAIN;
                            avm_read <= 1'b0;
                        end else begin
                            avm_read <= credit_ok;
                        end
                    end else if (!avm_read) begin
                        avm_read <= credit_ok;
                    end
                end
                ST_DRAIN: begin
                    if ((pending == '0) && (fifo_count == '0)) begin
                        state <= ST_FINISH;
                        done  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_mm_master_frame_reader.sv
// Self-checking bench: Avalon slave and stream sink models with a transfer-level scoreboard.
module tb_avalon_mm_master_frame_reader;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned LEN_W      = 24;
    localparam int unsigned MAX_PEND   = 4;
    localparam int unsigned FIFO_DEPTH = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_words;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    always #5 clk = ~clk;

    avalon_mm_master_frame_reader #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .LEN_W      (LEN_W),
        .MAX_PEND   (MAX_PEND),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_addr         (base_addr),
        .num_words         (num_words),
        .busy              (busy),
        .done              (done),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready)
    );

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      last_due = 0;
    logic [31:0] cur_base;
    int          cur_n, acc_idx, rsp_idx, pop_idx, done_cnt;
    int          lat_min, lat_max, wait_pct, ready_mode, stall_idx, stall_left;
    bit          inject_stale, prev_stall;
    longint      rsp_due[$];
    logic [31:0] rsp_data[$];

    // Memory contents seen by the slave: a fixed scramble of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    // One clock: drive slave/sink inputs for the next edge, score what happens at that edge.
    task automatic tick();
        bit          acc;
        bit          pop;
        longint      due;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        avm_readdatavalid = 1'b0;
        avm_readdata      = '0;
        avm_waitrequest   = 1'b0;
        if (reset) begin
            out_ready = 1'b0;
            rsp_due.delete();
            rsp_data.delete();
            prev_stall = 1'b0;
        end else begin
            if (inject_stale) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = 32'hDEAD_BEEF;
            end else if (rsp_due.size() != 0 && rsp_due[0] <= cyc) begin
                avm_readdatavalid = 1'b1;
                avm_readdata      = rsp_data.pop_front();
                void'(rsp_due.pop_front());
                rsp_idx++;
            end
            if (stall_left > 0 && avm_read === 1'b1 && acc_idx == stall_idx) begin
                avm_waitrequest = 1'b1;
                stall_left--;
            end else begin
                avm_waitrequest = ($urandom_range(99) < 32'(wait_pct));
            end
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(1));
            endcase
            acc = (avm_read === 1'b1) && !avm_waitrequest;
            pop = (out_valid === 1'b1) && out_ready;
            if (prev_stall) begin
                checks++;
                if (avm_read !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_read: avm_read=%b while stalled, required 1", avm_read);
                end
            end
            if (avm_read === 1'b1) begin
                exp_addr = cur_base + 32'(4 * acc_idx);
                checks++;
                if (acc_idx >= cur_n || avm_address !== exp_addr) begin
                    errors++;
                    $display("FAIL read_addr: addr=%h idx=%0d of %0d, required addr %h", avm_address, acc_idx, cur_n, exp_addr);
                end
            end
            if (pop) begin
                exp_data = mem_word(cur_base + 32'(4 * pop_idx));
                checks++;
                if (pop_idx >= cur_n || out_data !== exp_data) begin
                    errors++;
                    $display("FAIL stream_data: word %0d data=%h, required %h", pop_idx, out_data, exp_data);
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                checks++;
                if (acc_idx != cur_n || pop_idx != cur_n) begin
                    errors++;
                    $display("FAIL done_early: accepts=%0d pops=%0d, required %0d each", acc_idx, pop_idx, cur_n);
                end
            end
            if (acc) begin
                due = cyc + longint'($urandom_range(lat_max, lat_min));
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                rsp_due.push_back(due);
                rsp_data.push_back(mem_word(avm_address));
                acc_idx++;
            end
            if (pop) pop_idx++;
            checks++;
            if (acc_idx - rsp_idx > int'(MAX_PEND) || acc_idx - pop_idx > int'(FIFO_DEPTH)) begin
                errors++;
                $display("FAIL credit: outstanding=%0d held=%0d, required <=%0d and <=%0d",
                         acc_idx - rsp_idx, acc_idx - pop_idx, MAX_PEND, FIFO_DEPTH);
            end
            prev_stall = (avm_read === 1'b1) && avm_waitrequest;
        end
        @(negedge clk);
        #1;
        cyc++;
    endtask

    task automatic begin_xfer(input logic [31:0] base, input int n);
        cur_base = base;
        cur_n    = n;
        acc_idx  = 0;
        rsp_idx  = 0;
        pop_idx  = 0;
        done_cnt = 0;
        base_addr = base;
        num_words = LEN_W'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
        base_addr = $urandom;
        num_words = LEN_W'($urandom);
        checks++;
        if (n == 0) begin
            if (done !== 1'b1 || avm_read !== 1'b0) begin
                errors++;
                $display("FAIL zero_len: done=%b avm_read=%b, required done=1 read=0", done, avm_read);
            end
        end else if (avm_read !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL first_read: avm_read=%b busy=%b, required 1 and 1", avm_read, busy);
        end
    endtask

    task automatic finish_xfer(input int budget);
        int b = 0;
        while (done_cnt == 0 && b < budget) begin
            tick();
            b++;
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL done_pulse: done pulses=%0d within %0d cycles, required 1", done_cnt, budget);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_fall: busy=%b done=%b after done, required 0 and 0", busy, done);
        end
        checks++;
        if (acc_idx != cur_n || pop_idx != cur_n) begin
            errors++;
            $display("FAIL word_count: accepts=%0d pops=%0d, required %0d", acc_idx, pop_idx, cur_n);
        end
    endtask

    task automatic set_mode(input int lmin, input int lmax, input int wpct, input int rmode);
        lat_min = lmin; lat_max = lmax; wait_pct = wpct; ready_mode = rmode;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || avm_read !== 1'b0 || avm_address !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b read=%b addr=%h valid=%b, required all 0",
                     busy, done, avm_read, avm_address, out_valid);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        set_mode(2, 2, 0, 1);
        begin_xfer(32'h0000_1000, 4);
        finish_xfer(100);
    endtask

    task automatic test_waitrequest();
        set_mode(2, 2, 0, 1);
        stall_idx  = 1;
        stall_left = 3;
        begin_xfer(32'h0000_1000, 4);
        finish_xfer(100);
        checks++;
        if (stall_left != 0) begin
            errors++;
            $display("FAIL stall_used: stall cycles left=%0d, required 0", stall_left);
        end
    endtask

    task automatic test_backpressure();
        set_mode(2, 2, 0, 0);
        begin_xfer(32'h0000_5000, 16);
        repeat (40) tick();
        checks++;
        if (acc_idx != int'(FIFO_DEPTH) || pop_idx != 0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL backpressure: accepts=%0d pops=%0d valid=%b, required %0d 0 1",
                     acc_idx, pop_idx, out_valid, FIFO_DEPTH);
        end
        ready_mode = 1;
        finish_xfer(300);
    endtask

    task automatic test_zero_len();
        set_mode(2, 2, 0, 1);
        begin_xfer(32'h0000_7000, 0);
        finish_xfer(10);
    endtask

    task automatic test_restart_ignored();
        set_mode(2, 2, 0, 1);
        begin_xfer(32'h0000_2000, 8);
        repeat (2) tick();
        start     = 1'b1;
        base_addr = 32'h0000_9000;
        num_words = LEN_W'(3);
        tick();
        start = 1'b0;
        finish_xfer(200);
    endtask

    task automatic test_reset_mid();
        set_mode(2, 2, 0, 0);
        begin_xfer(32'h0000_3000, int'(32'h00FF_FFFF));
        repeat (6) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (avm_read !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: read=%b busy=%b valid=%b done=%b, required all 0",
                     avm_read, busy, out_valid, done);
        end
        cur_n = 0; acc_idx = 0; rsp_idx = 0; pop_idx = 0; done_cnt = 0;
        ready_mode   = 1;
        inject_stale = 1'b1;
        tick();
        inject_stale = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_rdv: out_valid=%b after stale response, required 0", out_valid);
        end
        repeat (3) tick();
        checks++;
        if (done_cnt != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_done_after_reset: done pulses=%0d busy=%b, required 0 and 0", done_cnt, busy);
        end
        begin_xfer(32'h0000_4000, 3);
        finish_xfer(200);
    endtask

    task automatic test_wrap();
        set_mode(2, 2, 0, 1);
        begin_xfer(32'hFFFF_FFF8, 4);
        finish_xfer(100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            set_mode(1, 5, 25, 2);
            begin_xfer($urandom & 32'hFFFF_FFFC, int'($urandom_range(40, 1)));
            finish_xfer(2000);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; avm_readdatavalid = 1'b0; out_ready = 1'b0;
        cur_base = '0; cur_n = 0; acc_idx = 0; rsp_idx = 0; pop_idx = 0; done_cnt = 0;
        stall_idx = 0; stall_left = 0; inject_stale = 1'b0; prev_stall = 1'b0;
        set_mode(2, 2, 0, 1);
        @(negedge clk);
        #1;
        test_reset();
        test_basic();
        test_waitrequest();
        test_backpressure();
        test_zero_len();
        test_restart_ignored();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
